// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state codes and reset constants for the fetch stage
package fetch_pkg;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_DEPTH   = 2;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_INC      = 2'd2;
    localparam logic [1:0] S_DISCARD  = 2'd3;
    localparam logic [1:0] RST_STATE  = S_IDLE;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: PC, instruction-memory and decode-side signals of the fetch stage
interface instr_fetch_unit_if import fetch_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic [ADDR_W-1:0]  pc_addr;
    logic               flush;
    logic               pc_inc;
    logic               im_req;
    logic [ADDR_W-1:0]  im_addr;
    logic               im_ack;
    logic [INSTR_W-1:0] im_data;
    logic               ir_valid;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_addr;
    logic               ir_ready;
    modport master (
        input  pc_addr, flush, im_ack, im_data, ir_ready,
        output pc_inc, im_req, im_addr, ir_valid, ir_data, ir_addr
    );
    modport slave (
        output pc_addr, flush, im_ack, im_data, ir_ready,
        input  pc_inc, im_req, im_addr, ir_valid, ir_data, ir_addr
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {addr, instr} with clear priority and zeroed head when empty
module fetch_queue import fetch_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1,
    localparam int EW     = ADDR_W + INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_addr,
    input  logic [INSTR_W-1:0] push_data,
    input  logic               pop,
    output logic [CW-1:0]      count,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_addr,
    output logic [INSTR_W-1:0] head_data
);
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign do_pop     = pop & (count_q != '0);
    assign count      = count_q;
    assign head_valid = count_q != '0;
    assign head_addr  = head_valid ? mem_q[rd_ptr_q][EW-1:INSTR_W] : '0;
    assign head_data  = head_valid ? mem_q[rd_ptr_q][INSTR_W-1:0] : '0;

    // next pointers/count/storage; clear wins over push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {push_addr, push_data};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    // queue state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding req/ack instruction fetcher feeding a small decode queue
module instr_fetch_unit import fetch_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input logic              clk,
    input logic              rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        state_q, state_d;
    logic              im_req_q, im_req_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              push;
    logic [CW-1:0]     count;

    fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (bus.flush),
        .push       (push),
        .push_addr  (im_addr_q),
        .push_data  (bus.im_data),
        .pop        (bus.ir_ready),
        .count      (count),
        .head_valid (bus.ir_valid),
        .head_addr  (bus.ir_addr),
        .head_data  (bus.ir_data)
    );

    assign bus.im_req  = im_req_q;
    assign bus.im_addr = im_addr_q;
    // gated by flush so the PC never sees a write and an increment together
    assign bus.pc_inc  = (state_q == S_INC) & ~bus.flush;

    // fetch FSM: issue, wait for ack, strobe PC; a flush mid-request drains the ack before reissuing
    always_comb begin
        state_d   = state_q;
        im_req_d  = im_req_q;
        im_addr_d = im_addr_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: if (!bus.flush && count < CW'(DEPTH)) begin
                im_req_d  = 1'b1;
                im_addr_d = bus.pc_addr;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: if (bus.im_ack) begin
                im_req_d = 1'b0;
                push     = ~bus.flush;
                state_d  = bus.flush ? S_IDLE : S_INC;
            end else if (bus.flush) begin
                state_d = S_DISCARD;
            end
            S_DISCARD: if (bus.im_ack) begin
                im_req_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            im_req_q  <= 1'b0;
            im_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            im_req_q  <= im_req_d;
            im_addr_q <= im_addr_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: transaction-level model of the fetch stage plus a PC register model
module tb_instr_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus();
    instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
    ent_t        q[$];
    bit          m_out, m_disc, m_inc;
    logic [15:0] m_addr, pc, load_val;
    int          checks, errors;

    assign bus.pc_addr = pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out = 0; m_disc = 0; m_inc = 0; m_addr = '0;
    endtask

    // compare on the negedge, then advance model and PC across the posedge
    task automatic step();
        bit   s_inc, issue, pushing, n_inc;
        ent_t e;
        @(negedge clk);
        chk("im_req", {31'b0, bus.im_req}, {31'b0, m_out});
        if (m_out) chk("im_addr", {16'b0, bus.im_addr}, {16'b0, m_addr});
        chk("pc_inc", {31'b0, bus.pc_inc}, {31'b0, m_inc & !bus.flush});
        chk("ir_valid", {31'b0, bus.ir_valid}, {31'b0, q.size() != 0});
        chk("ir_data", {16'b0, bus.ir_data}, q.size() != 0 ? {16'b0, q[0].d} : 32'h0);
        chk("ir_addr", {16'b0, bus.ir_addr}, q.size() != 0 ? {16'b0, q[0].a} : 32'h0);
        s_inc = bus.pc_inc;
        @(posedge clk);
        issue   = !m_out && !m_inc && !bus.flush && q.size() < DEPTH;
        pushing = 0;
        n_inc   = 0;
        if (m_out && bus.im_ack) begin
            m_out = 0;
            if (!m_disc && !bus.flush) begin pushing = 1; n_inc = 1; end
        end else if (m_out && bus.flush) begin
            m_disc = 1;
        end
        if (bus.flush) q.delete();
        else begin
            if (bus.ir_ready && q.size() != 0) void'(q.pop_front());
            if (pushing) begin e.a = m_addr; e.d = bus.im_data; q.push_back(e); end
        end
        if (issue) begin m_out = 1; m_addr = pc; m_disc = 0; end
        m_inc = n_inc;
        if (bus.flush) pc = load_val;
        else if (s_inc) pc = pc + 16'd1;
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.flush = 0; bus.im_ack = 0; bus.im_data = '0; bus.ir_ready = 0;
        load_val = '0; pc = 16'h00FF;
        model_reset();
        #12;
        chk("rst_im_req", {31'b0, bus.im_req}, 32'h0);
        chk("rst_im_addr", {16'b0, bus.im_addr}, 32'h0);
        chk("rst_pc_inc", {31'b0, bus.pc_inc}, 32'h0);
        chk("rst_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
        chk("rst_ir_data", {16'b0, bus.ir_data}, 32'h0);
        chk("rst_ir_addr", {16'b0, bus.ir_addr}, 32'h0);
        @(posedge clk); #1 rst_n = 1;
        // basic fetch with ack two cycles after request
        step();
        chk("t1_addr", {16'b0, bus.im_addr}, 32'h00FF);
        step();
        bus.im_ack = 1; bus.im_data = 16'hA5A5;
        step();
        bus.im_ack = 0;
        chk("t1_pc_inc", {31'b0, bus.pc_inc}, 32'h1);
        chk("t1_ir_data", {16'b0, bus.ir_data}, 32'hA5A5);
        chk("t1_ir_addr", {16'b0, bus.ir_addr}, 32'h00FF);
        step();
        chk("t1_pc", {16'b0, pc}, 32'h0100);
        // wrap from 0xFFFF
        bus.flush = 1; load_val = 16'hFFFF;
        step();
        bus.flush = 0;
        step();
        chk("t5_addr", {16'b0, bus.im_addr}, 32'hFFFF);
        bus.im_ack = 1; bus.im_data = 16'h1234;
        step();
        bus.im_ack = 0;
        chk("t5_ir_addr", {16'b0, bus.ir_addr}, 32'hFFFF);
        chk("t5_ir_data", {16'b0, bus.ir_data}, 32'h1234);
        step();
        step();
        chk("t5_next", {16'b0, bus.im_addr}, 32'h0000);
        // flush while waiting for ack
        bus.flush = 1; load_val = 16'h0040;
        step();
        bus.flush = 0;
        step();
        step();
        bus.im_ack = 1; bus.im_data = 16'hDEAD;
        step();
        bus.im_ack = 0;
        chk("t3_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
        chk("t3_im_req", {31'b0, bus.im_req}, 32'h0);
        chk("t3_pc", {16'b0, pc}, 32'h0040);
        step();
        chk("t3_next", {16'b0, bus.im_addr}, 32'h0040);
        bus.im_ack = 1; bus.im_data = 16'h0001;
        step();
        bus.im_ack = 0;
        step();
        // backpressure fills the queue
        bus.flush = 1; load_val = 16'h0010;
        step();
        bus.flush = 0;
        step();
        chk("t2_a0", {16'b0, bus.im_addr}, 32'h0010);
        bus.im_ack = 1; bus.im_data = 16'h1111;
        step();
        bus.im_ack = 0;
        step();
        step();
        chk("t2_a1", {16'b0, bus.im_addr}, 32'h0011);
        bus.im_ack = 1; bus.im_data = 16'h2222;
        step();
        bus.im_ack = 0;
        step();
        step();
        step();
        chk("t2_stall", {31'b0, bus.im_req}, 32'h0);
        chk("t2_head", {16'b0, bus.ir_addr}, 32'h0010);
        bus.ir_ready = 1;
        step();
        bus.ir_ready = 0;
        chk("t2_head2", {16'b0, bus.ir_addr}, 32'h0011);
        step();
        chk("t2_a2", {16'b0, bus.im_addr}, 32'h0012);
        // simultaneous push and pop at count 1
        bus.im_ack = 1; bus.im_data = 16'h3333; bus.ir_ready = 1;
        step();
        bus.im_ack = 0; bus.ir_ready = 0;
        chk("t6_valid", {31'b0, bus.ir_valid}, 32'h1);
        chk("t6_head", {16'b0, bus.ir_addr}, 32'h0012);
        chk("t6_data", {16'b0, bus.ir_data}, 32'h3333);
        step();
        // flush during the increment cycle
        step();
        bus.im_ack = 1; bus.im_data = 16'h4444;
        step();
        bus.im_ack = 0;
        bus.flush = 1; load_val = 16'h0200;
        #1 chk("t4_pc_inc", {31'b0, bus.pc_inc}, 32'h0);
        step();
        bus.flush = 0;
        chk("t4_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
        step();
        chk("t4_next", {16'b0, bus.im_addr}, 32'h0200);
        // async reset during WAIT_ACK
        #2 rst_n = 0;
        #1;
        chk("ar_im_req", {31'b0, bus.im_req}, 32'h0);
        chk("ar_im_addr", {16'b0, bus.im_addr}, 32'h0);
        chk("ar_ir_valid", {31'b0, bus.ir_valid}, 32'h0);
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.flush    = ($urandom % 16) == 0;
            load_val     = 16'($urandom);
            bus.im_ack   = $urandom % 2;
            bus.im_data  = 16'($urandom);
            bus.ir_ready = ($urandom % 3) != 0;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
